// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
// Four requesters share one 8x8 multiplier through a round-robin arbiter.
// Pipeline: S1 holds the granted operands and feeds the multiplier. S2 holds
// the product and drives the res_* outputs. With no output stall a transfer
// in cycle t appears on res_* in cycle t+2.
// Optional feature: define MULT_ARB_LOCK_EN to honour req_lock, which keeps
// priority on a requester across a back-to-back burst.
module mult_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*W-1:0]   req_a_i,
    input  logic [NREQ*W-1:0]   req_b_i,
    input  logic [NREQ-1:0]     req_lock_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic                res_valid_o,
    output logic [2*W-1:0]      res_prod_o,
    output logic [1:0]          res_id_o,
    input  logic                res_ready_i
);

    logic           s1_valid_q;
    logic [W-1:0]   s1_a_q;
    logic [W-1:0]   s1_b_q;
    logic [1:0]     s1_id_q;
    logic           s2_valid_q;
    logic [2*W-1:0] s2_prod_q;
    logic [1:0]     s2_id_q;
    logic [1:0]     ptr_q;
    logic [1:0]     ptr_d;

    logic           adv1;
    logic           adv2;
    logic           xfer;
    logic [1:0]     gnt_idx;
    logic [1:0]     scan_idx;
    logic [2*W-1:0] mult_p;

    // Pipeline advance: S2 moves when empty or drained; S1 moves when S2 makes room.
    always_comb begin
        adv2 = !s2_valid_q || res_ready_i;
        adv1 = !s1_valid_q || adv2;
    end

    // Round-robin search starting at ptr_q; no grant in reset or when S1 cannot load.
    always_comb begin
        gnt_o    = '0;
        gnt_idx  = ptr_q;
        scan_idx = ptr_q;
        xfer     = 1'b0;
        if (rst_n_i && adv1 && (|req_i)) begin
            for (int k = 0; k < NREQ; k++) begin
                scan_idx = ptr_q + 2'(k);
                if (!xfer && req_i[scan_idx]) begin
                    xfer    = 1'b1;
                    gnt_idx = scan_idx;
                end
            end
        end
        if (xfer) begin
            gnt_o[gnt_idx] = 1'b1;
        end
    end

    // Next priority pointer; a locked transfer keeps priority on the same requester.
`ifdef MULT_ARB_LOCK_EN
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = req_lock_i[gnt_idx] ? gnt_idx : gnt_idx + 2'd1;
        end
    end
`else
    logic unused_req_lock;
    assign unused_req_lock = ^req_lock_i;

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = gnt_idx + 2'd1;
        end
    end
`endif

    // The shared combinational multiplier, fed only from registered operands.
    always_comb begin
        mult_p = (2*W)'(s1_a_q) * (2*W)'(s1_b_q);
    end

    // Priority pointer register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    // S1 operand stage: captures the granted request, or goes empty with no grant.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= 2'd0;
        end else if (adv1) begin
            s1_valid_q <= xfer;
            if (xfer) begin
                s1_a_q  <= req_a_i[gnt_idx*W +: W];
                s1_b_q  <= req_b_i[gnt_idx*W +: W];
                s1_id_q <= gnt_idx;
            end
        end
    end

    // S2 product stage: holds steady while the consumer stalls.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_id_q    <= 2'd0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            s2_prod_q  <= mult_p;
            s2_id_q    <= s1_id_q;
        end
    end

    assign res_valid_o = s2_valid_q;
    assign res_prod_o  = s2_prod_q;
    assign res_id_o    = s2_id_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Testbench for mult_share_arbiter: scoreboard of expected results plus a
// behavioural model of grant order and pipeline occupancy.
module tb_mult_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_lock;
    logic [3:0]  gnt;
    logic        res_valid;
    logic [15:0] res_prod;
    logic [1:0]  res_id;
    logic        res_ready;

    mult_share_arbiter dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .req_i       (req),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_lock_i  (req_lock),
        .gnt_o       (gnt),
        .res_valid_o (res_valid),
        .res_prod_o  (res_prod),
        .res_id_o    (res_id),
        .res_ready_i (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [15:0] prod;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // model state: occupancy of the two pipeline slots and the priority pointer
    bit   m1_v = 1'b0;
    bit   m2_v = 1'b0;
    int   ptr_m = 0;
    int   last_gi = -1;
    logic [3:0] last_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    // One clock cycle: check grant and valid at the negedge, advance the model, then
    // return 1ns after the rising edge so the caller can drive the next cycle.
    task automatic step();
        bit         adv1;
        bit         adv2;
        logic [3:0] eg;
        int         gi;
        exp_t       e;
        @(negedge clk);
        adv2 = !m2_v || res_ready;
        adv1 = !m1_v || adv2;
        eg   = 4'd0;
        gi   = -1;
        if (rst_n && adv1) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (ptr_m + k) % 4;
                if (gi < 0 && req[j]) gi = j;
            end
        end
        if (gi >= 0) eg[gi] = 1'b1;
        chk("gnt", {28'd0, gnt}, {28'd0, eg});
        chk("res_valid", {31'd0, res_valid}, {31'd0, m2_v});
        last_gnt = gnt;
        if (!rst_n) begin
            m1_v  = 1'b0;
            m2_v  = 1'b0;
            ptr_m = 0;
            exp_q.delete();
        end else begin
            if (gi >= 0) begin
                e.id   = 2'(gi);
                e.prod = 16'(req_a[gi*8 +: 8]) * 16'(req_b[gi*8 +: 8]);
                exp_q.push_back(e);
`ifdef MULT_ARB_LOCK_EN
                ptr_m = req_lock[gi] ? gi : (gi + 1) % 4;
`else
                ptr_m = (gi + 1) % 4;
`endif
            end
            if (adv2) m2_v = m1_v;
            if (adv1) m1_v = (gi >= 0);
        end
        last_gi = gi;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int k;
        req       = 4'd0;
        res_ready = 1'b1;
        k = 0;
        while ((exp_q.size() != 0 || m1_v || m2_v) && k < 10) begin
            step();
            k++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: pops on every accepted result, checks holds during stalls.
    logic        stall_prev = 1'b0;
    logic [15:0] held_p;
    logic [1:0]  held_id;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid) begin
            if (stall_prev) begin
                chk("stall_prod", {16'd0, res_prod}, {16'd0, held_p});
                chk("stall_id", {30'd0, res_id}, {30'd0, held_id});
            end
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_result: got id %0d prod %h expected none", res_id, res_prod);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_prod", {16'd0, res_prod}, {16'd0, e.prod});
                    chk("res_id", {30'd0, res_id}, {30'd0, e.id});
                end
            end
        end
        stall_prev = rst_n && res_valid && !res_ready;
        held_p     = res_prod;
        held_id    = res_id;
    end

    logic [3:0] seq_exp [6];

    initial begin
        rst_n     = 1'b0;
        req       = 4'd0;
        req_a     = 32'd0;
        req_b     = 32'd0;
        req_lock  = 4'd0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset state
        do_reset();
        chk("rst_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_prod", {16'd0, res_prod}, 32'd0);
        chk("rst_id", {30'd0, res_id}, 32'd0);

        // single op, latency 2
        set_op(0, 8'h0C, 8'h0D);
        req = 4'b0001;
        step();
        chk("single_gnt", {28'd0, last_gnt}, 32'd1);
        req = 4'd0;
        step();
        step();
        chk("single_prod", {16'd0, res_prod}, 32'h009C);
        step();
        chk("single_after", {31'd0, res_valid}, 32'd0);

        // all four held: strict rotation
        for (int i = 0; i < 4; i++) set_op(i, 8'((i + 1) * 8'h11), 8'h02);
        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
        seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001;
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_seq", {28'd0, last_gnt}, {28'd0, seq_exp[k]});
        end
        drain();

        // backpressure
        do_reset();
        req       = 4'b1111;
        res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_inflight", {31'd0, (exp_q.size() <= 2)}, 32'd1);
        end
        chk("bp_gnt_blocked", {28'd0, last_gnt}, 32'd0);
        drain();

        // corner operands
        set_op(2, 8'hFF, 8'hFF);
        set_op(3, 8'h00, 8'hA5);
        set_op(1, 8'h80, 8'h02);
        req = 4'b0100; step(); req = 4'd0; step(); step();
        chk("corner_ff", {16'd0, res_prod}, 32'hFE01);
        req = 4'b1000; step(); req = 4'd0; step(); step();
        chk("corner_zero", {16'd0, res_prod}, 32'h0000);
        req = 4'b0010; step(); req = 4'd0; step(); step();
        chk("corner_80", {16'd0, res_prod}, 32'h0100);
        drain();

        // reset with both stages full
        for (int i = 0; i < 4; i++) set_op(i, 8'(8'h21 + i), 8'h03);
        req       = 4'b0110;
        res_ready = 1'b0;
        step();
        step();
        chk("mid_full", {31'd0, m1_v && m2_v}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        req       = 4'b1111;
        res_ready = 1'b1;
        step();
        chk("mid_rst_gnt", {28'd0, last_gnt}, 32'd1);
        drain();

        // lock hint stimulus
`ifdef MULT_ARB_LOCK_EN
        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0010;
        seq_exp[3] = 4'b0010; seq_exp[4] = 4'b0010; seq_exp[5] = 4'b0100;
`else
        seq_exp[0] = 4'b0001; seq_exp[1] = 4'b0010; seq_exp[2] = 4'b0100;
        seq_exp[3] = 4'b1000; seq_exp[4] = 4'b0001; seq_exp[5] = 4'b0010;
`endif
        do_reset();
        req      = 4'b1111;
        req_lock = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            if (k == 4) req_lock = 4'b0000;
            step();
            chk("lock_seq", {28'd0, last_gnt}, {28'd0, seq_exp[k]});
        end
        req_lock = 4'd0;
        drain();

        // randomized traffic with held requests, random stalls and rare resets
        do_reset();
        for (int c = 0; c < 600; c++) begin
            step();
            if (last_gi >= 0) req[last_gi] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    if ($urandom_range(0, 7) == 0) set_op(i, 8'hFF, 8'($urandom_range(0, 255)));
                    else set_op(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    req[i] = 1'b1;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            req_lock  = 4'($urandom_range(0, 15));
            rst_n     = ($urandom_range(0, 149) != 0);
        end
        rst_n    = 1'b1;
        req_lock = 4'd0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
